// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state codes, parity types, clog2 helper.
// Latency: n/a (definitions only); backpressure: n/a.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART serialiser; wrap-around pointers carry an extra MSB.
// Latency: pushed word visible at head one cycle later; backpressure: o_full, pushes while full are dropped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_pop_dat,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with input FIFO: start|data LSB-first|[parity]|1-2 stop bits, programmable bit period.
// Latency: word pushed into empty FIFO while idle drives the start bit from the next edge; backpressure: Ready=!full, drops flagged by Overflow.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_Valid,
    output logic                  Ready,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_Out,
    output logic                  Busy,
    output logic                  Overflow
);

    localparam int BW = clog2(DATA_WIDTH);

    logic [2:0]            r_state;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_stop_idx;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_presc_cnt;
    logic [BW-1:0]         r_bit_cnt;

    logic [DATA_WIDTH-1:0] w_fifo_dat;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_par_bit;

    uart_tx_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_push     (Data_Valid),
        .i_push_dat (P_Data),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign Ready    = ~w_full;
    assign TX_Out   = r_tx;
    assign Busy     = r_busy;
    assign Overflow = r_overflow;

    assign w_bit_end   = (r_presc_cnt == r_presc - PRESCALE_W'(1));
    assign w_last_stop = (r_state == STOP) && w_bit_end && (!r_stop2 || r_stop_idx);
    // A new frame launches from idle or straight out of the final stop bit, so back-to-back words leave no gap.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_last_stop);
    assign w_par_bit   = (PAR_TYP == PAR_ODD) ? ~^w_fifo_dat : ^w_fifo_dat;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_shift     <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop2     <= 1'b0;
            r_stop_idx  <= 1'b0;
            r_presc     <= PRESCALE_W'(1);
            r_presc_cnt <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_overflow <= Data_Valid & w_full;
            if (w_pop) begin
                // Frame settings are frozen here; later input changes wait for the next frame.
                r_state     <= START;
                r_tx        <= 1'b0;
                r_busy      <= 1'b1;
                r_shift     <= w_fifo_dat;
                r_par_en    <= PAR_EN;
                r_par_bit   <= w_par_bit;
                r_stop2     <= STOP2;
                r_stop_idx  <= 1'b0;
                r_presc     <= (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
                r_presc_cnt <= '0;
                r_bit_cnt   <= '0;
            end else if (r_state != IDLE) begin
                if (!w_bit_end) begin
                    r_presc_cnt <= r_presc_cnt + PRESCALE_W'(1);
                end else begin
                    r_presc_cnt <= '0;
                    case (r_state)
                        START: begin
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                        end
                        DATA: begin
                            if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
                                if (r_par_en) begin
                                    r_state <= PARITY;
                                    r_tx    <= r_par_bit;
                                end else begin
                                    r_state <= STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end
                        PARITY: begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end
                        STOP: begin
                            if (r_stop2 && !r_stop_idx) begin
                                r_stop_idx <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_tx    <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised and directed bench for uart_tx_buffered: frame-level reference model feeds a scoreboard
// queue that a serial-line monitor drains, while Busy/Ready/Overflow are compared cycle by cycle.
module tb_uart_tx_buffered;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 6;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_Data;
    logic          Data_Valid;
    logic          Ready;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic [PW-1:0] Prescale;
    logic          TX_Out;
    logic          Busy;
    logic          Overflow;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          presc;
    } frame_t;

    int          n_cmp = 0;
    int          n_err = 0;
    frame_t      exp_q[$];
    logic [7:0]  pend[$];
    int          rem = 0;
    bit          exp_busy = 0;
    bit          exp_ovf = 0;
    bit          exp_ready = 1;
    int          frames_exp = 0;
    int          frames_seen = 0;
    bit          mon_active = 0;

    uart_tx_buffered #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_Data     (P_Data),
        .Data_Valid (Data_Valid),
        .Ready      (Ready),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Prescale   (Prescale),
        .TX_Out     (TX_Out),
        .Busy       (Busy),
        .Overflow   (Overflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line levels for one frame, built from the framing rules.
    function automatic frame_t make_frame(input logic [7:0] d, input bit pe, input bit pt,
                                          input bit s2, input int p);
        frame_t f;
        int     n;
        int     ones;
        f.bits = '0;
        n = 0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DW; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (pe) begin
            ones = $countones(d);
            f.bits[n] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        f.presc = p;
        return f;
    endfunction

    // Reference model: FIFO as a queue, transmitter as a remaining-cycles counter.
    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                if (rem > 0) frames_exp--;
                pend.delete();
                exp_q.delete();
                rem       = 0;
                exp_busy  = 0;
                exp_ovf   = 0;
                exp_ready = 1;
            end else begin
                bit accept;
                int pre;
                pre     = pend.size();
                accept  = Data_Valid && (pre < DEPTH);
                exp_ovf = Data_Valid && (pre == DEPTH);
                if (rem > 0) rem--;
                if (rem == 0 && pend.size() > 0) begin
                    frame_t     f;
                    logic [7:0] d;
                    int         p;
                    d = pend.pop_front();
                    p = (Prescale == 0) ? 1 : int'(Prescale);
                    f = make_frame(d, PAR_EN, PAR_TYP, STOP2, p);
                    exp_q.push_back(f);
                    rem = p * f.nbits;
                    frames_exp++;
                end
                if (accept) pend.push_back(P_Data);
                exp_busy  = (rem > 0);
                exp_ready = (pend.size() < DEPTH);
            end
        end
    end

    // Monitor: per-cycle status checks and serial-line decode against the scoreboard.
    initial begin
        frame_t cur;
        int     bi;
        int     ci;
        bit     bad;
        logic   expb;
        bi  = 0;
        ci  = 0;
        bad = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                mon_active = 0;
            end else begin
                check("busy", int'(Busy), int'(exp_busy));
                check("ready", int'(Ready), int'(exp_ready));
                check("overflow", int'(Overflow), int'(exp_ovf));
                if (!exp_busy) check("idle_line", int'(TX_Out), 1);
                if (!mon_active && TX_Out == 1'b0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_frame: start bit seen with no frame expected at %0t", $time);
                    end else begin
                        cur        = exp_q.pop_front();
                        mon_active = 1;
                        bi         = 0;
                        ci         = 0;
                        bad        = 0;
                    end
                end
                if (mon_active) begin
                    expb = cur.bits[bi];
                    if (TX_Out !== expb) bad = 1;
                    ci++;
                    if (ci == cur.presc) begin
                        check($sformatf("frame%0d_bit%0d", frames_seen, bi),
                              bad ? int'(!expb) : int'(expb), int'(expb));
                        bi++;
                        ci  = 0;
                        bad = 0;
                        if (bi == cur.nbits) begin
                            mon_active = 0;
                            frames_seen++;
                        end
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        Data_Valid = 1'b1;
        P_Data     = d;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((rem != 0 || pend.size() != 0 || mon_active) && k < budget) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("idle_timeout", int'(k < budget), 1);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        int s0;
        int lows;
        RST        = 1'b1;
        Data_Valid = 1'b0;
        P_Data     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        Prescale   = 6'd1;
        #2;
        RST = 1'b0;
        #1;
        check("rst_tx", int'(TX_Out), 1);
        check("rst_busy", int'(Busy), 0);
        check("rst_ready", int'(Ready), 1);
        check("rst_overflow", int'(Overflow), 0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // 0xA5 even parity, 1 clock per bit
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 6'd1;
        push(8'hA5);
        wait_idle(200);

        // 0xFF odd parity
        PAR_TYP = 1'b1;
        push(8'hFF);
        wait_idle(200);

        // 0x3C, 4 clocks per bit, two stop bits
        PAR_EN = 1'b0; STOP2 = 1'b1; Prescale = 6'd4;
        push(8'h3C);
        wait_idle(200);

        // Overfill: six consecutive pushes, one dropped, five back-to-back frames
        STOP2 = 1'b0; Prescale = 6'd1;
        s0 = frames_seen;
        for (int d = 1; d <= 6; d++) begin
            push(8'(d));
        end
        wait_idle(400);
        check("overfill_frames", frames_seen - s0, 5);

        // Asynchronous reset in the middle of data bit 3
        Prescale = 6'd4;
        push(8'h5A);
        repeat (17) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("midreset_tx", int'(TX_Out), 1);
        check("midreset_busy", int'(Busy), 0);
        check("midreset_ready", int'(Ready), 1);
        repeat (2) @(posedge CLK);
        #1;
        RST  = 1'b1;
        lows = 0;
        repeat (30) begin
            @(negedge CLK);
            if (!TX_Out) lows++;
        end
        check("post_reset_quiet", lows, 0);
        @(posedge CLK);
        #1;

        // Settings change mid-frame apply only to the next frame
        Prescale = 6'd2; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        s0 = frames_seen;
        push(8'h96);
        push(8'h69);
        repeat (4) @(posedge CLK);
        #1;
        Prescale = 6'd5; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        wait_idle(400);
        check("midchange_frames", frames_seen - s0, 2);

        // Random traffic with occasional setting changes, including prescale 0
        for (int i = 0; i < 1500; i++) begin
            Data_Valid = ($urandom_range(2) == 0);
            P_Data     = 8'($urandom);
            if ($urandom_range(15) == 0) begin
                Prescale = 6'($urandom_range(5));
                PAR_EN   = 1'($urandom_range(1));
                PAR_TYP  = 1'($urandom_range(1));
                STOP2    = 1'($urandom_range(1));
            end
            @(posedge CLK);
            #1;
        end
        Data_Valid = 1'b0;
        wait_idle(3000);

        check("frames_total", frames_seen, frames_exp);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
